packet_reassembler: RTL and testbench

- Parametrised successor to the NoC-side packet collector.
- Reassembles flits from the network into whole packets. Flits are keyed by (source node, packet id) and may arrive out of order and interleaved across packets.
- Generalises flit width, flits per packet and buffer depth.
- Adds valid/ready backpressure on both sides, timeout eviction of stale partial packets, and duplicate/drop statistics.
- Sits between the NoC receive port and the core-side packet consumer.

---
 rtl/packet_reassembler.sv | 235 +++++++++++++++++++++++
 tb/tb_packet_reassembler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_reassembler.sv
// Reassembles out-of-order, interleaved NoC flits into whole packets keyed by
// (source node, packet id), with timeout eviction and duplicate/drop counters.

module packet_reassembler_entry #(
  parameter int NODE_W         = 3,
  parameter int PID_W          = 5,
  parameter int DATA_W         = 17,
  parameter int FLITS          = 4,
  parameter int IDX_W          = 2,
  parameter int AGE_W          = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic                            i_alloc,
  input  logic                            i_tgt,
  input  logic                            i_take,
  input  logic [NODE_W-1:0]               i_src,
  input  logic [NODE_W-1:0]               i_dst,
  input  logic [PID_W-1:0]                i_pid,
  input  logic [IDX_W-1:0]                i_idx,
  input  logic [DATA_W-1:0]               i_data,
  output logic                            o_vld,
  output logic                            o_cmpl,
  output logic                            o_tmo,
  output logic                            o_dup,
  output logic [NODE_W-1:0]               o_src,
  output logic [NODE_W-1:0]               o_dst,
  output logic [PID_W-1:0]                o_pid,
  output logic [FLITS-1:0][DATA_W-1:0]    o_data
);
  logic                         r_vld;
  logic [FLITS-1:0]             r_mask;
  logic [FLITS-1:0][DATA_W-1:0] r_data;
  logic [NODE_W-1:0]            r_src, r_dst;
  logic [PID_W-1:0]             r_pid;
  logic [AGE_W-1:0]             r_age;
  logic                         w_full;

  assign w_full = &r_mask;
  assign o_vld  = r_vld;
  assign o_cmpl = r_vld && w_full;
  assign o_dup  = i_tgt && r_mask[i_idx];
  assign o_src  = r_src;
  assign o_dst  = r_dst;
  assign o_pid  = r_pid;
  assign o_data = r_data;

  // A flit landing on this entry in the expiry cycle keeps it alive.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      assign o_tmo = r_vld && !w_full && !i_tgt && (r_age == AGE_W'(TIMEOUT_CYCLES-1));
    end else begin : g_no_tmo
      assign o_tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_mask <= '0;
      r_data <= '0;
      r_src  <= '0;
      r_dst  <= '0;
      r_pid  <= '0;
      r_age  <= '0;
    end else if (ce) begin
      if (i_alloc) begin
        r_vld         <= 1'b1;
        r_src         <= i_src;
        r_dst         <= i_dst;
        r_pid         <= i_pid;
        r_mask        <= FLITS'(1) << i_idx;
        r_data[i_idx] <= i_data;
        r_age         <= '0;
      end else begin
        if (i_take || o_tmo) r_vld <= 1'b0;
        if (i_tgt) begin
          r_mask[i_idx] <= 1'b1;
          if (!w_full) r_data[i_idx] <= i_data;
          r_age <= '0;
        end else if (r_vld && !w_full) begin
          r_age <= r_age + 1'b1;
        end
      end
    end
  end
endmodule

module packet_reassembler #(
  parameter int NODE_COUNT       = 8,
  parameter int PACKET_ID_WIDTH  = 5,
  parameter int FLIT_DATA_W      = 17,
  parameter int FLITS_PER_PACKET = 4,
  parameter int BUFFER_SIZE      = 8,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int NODE_W = $clog2(NODE_COUNT),
  localparam int IDX_W  = $clog2(FLITS_PER_PACKET),
  localparam int PKT_W  = FLITS_PER_PACKET*FLIT_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NODE_W-1:0]          in_node_start,
  input  logic [NODE_W-1:0]          in_node_dest,
  input  logic [PACKET_ID_WIDTH-1:0] in_packet_id,
  input  logic [IDX_W-1:0]           in_flit_index,
  input  logic [FLIT_DATA_W-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PKT_W-1:0]           out_data,
  output logic [NODE_W-1:0]          out_node_start,
  output logic [NODE_W-1:0]          out_node_dest,
  output logic [PACKET_ID_WIDTH-1:0] out_packet_id,
  output logic [15:0]                drop_count,
  output logic [15:0]                dup_count
);
  localparam int AGE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BUF_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE+1);

  logic [BUFFER_SIZE-1:0]                                       w_vld, w_hit, w_cmpl, w_tmo, w_dup;
  logic [BUFFER_SIZE-1:0]                                       w_alloc, w_take;
  logic [BUFFER_SIZE-1:0][NODE_W-1:0]                           w_src, w_dst;
  logic [BUFFER_SIZE-1:0][PACKET_ID_WIDTH-1:0]                  w_pid;
  logic [BUFFER_SIZE-1:0][FLITS_PER_PACKET-1:0][FLIT_DATA_W-1:0] w_data;
  logic [BUF_W-1:0]   w_free_idx, w_cmpl_idx;
  logic               w_any_hit, w_acc, w_load;
  logic [CNT_W-1:0]   w_ndrop;
  logic [PKT_W-1:0]   w_pkt;
  logic [16:0]        w_drop_sum, w_dup_sum;

  logic                       r_out_valid;
  logic [PKT_W-1:0]           r_out_data;
  logic [NODE_W-1:0]          r_out_src, r_out_dst;
  logic [PACKET_ID_WIDTH-1:0] r_out_pid;
  logic [15:0]                r_drop, r_dup;

  assign w_any_hit = |w_hit;
  assign in_ready  = ce && (w_any_hit || !(&w_vld));
  assign w_acc     = in_valid && in_ready;
  assign w_load    = ce && (!r_out_valid || out_ready);

  // Lowest-index free and complete entries; descending scan so the lowest wins.
  always_comb begin
    w_free_idx = '0;
    w_cmpl_idx = '0;
    for (int i = BUFFER_SIZE-1; i >= 0; i--) begin
      if (!w_vld[i]) w_free_idx = BUF_W'(i);
      if (w_cmpl[i]) w_cmpl_idx = BUF_W'(i);
    end
  end

  for (genvar g = 0; g < BUFFER_SIZE; g++) begin : g_ent
    assign w_hit[g]   = w_vld[g] && (w_src[g] == in_node_start) && (w_pid[g] == in_packet_id);
    assign w_alloc[g] = w_acc && !w_any_hit && (w_free_idx == BUF_W'(g));
    assign w_take[g]  = w_load && w_cmpl[g] && (w_cmpl_idx == BUF_W'(g));

    packet_reassembler_entry #(
      .NODE_W(NODE_W), .PID_W(PACKET_ID_WIDTH), .DATA_W(FLIT_DATA_W),
      .FLITS(FLITS_PER_PACKET), .IDX_W(IDX_W), .AGE_W(AGE_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ce),
      .i_alloc(w_alloc[g]),
      .i_tgt  (w_acc && w_hit[g]),
      .i_take (w_take[g]),
      .i_src  (in_node_start),
      .i_dst  (in_node_dest),
      .i_pid  (in_packet_id),
      .i_idx  (in_flit_index),
      .i_data (in_data),
      .o_vld  (w_vld[g]),
      .o_cmpl (w_cmpl[g]),
      .o_tmo  (w_tmo[g]),
      .o_dup  (w_dup[g]),
      .o_src  (w_src[g]),
      .o_dst  (w_dst[g]),
      .o_pid  (w_pid[g]),
      .o_data (w_data[g])
    );
  end

  // Flit 0 goes to the most significant slice of the packet.
  always_comb begin
    w_pkt = '0;
    for (int j = 0; j < FLITS_PER_PACKET; j++)
      w_pkt[(FLITS_PER_PACKET-1-j)*FLIT_DATA_W +: FLIT_DATA_W] = w_data[w_cmpl_idx][j];
  end

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < BUFFER_SIZE; i++) w_ndrop = w_ndrop + CNT_W'(w_tmo[i]);
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
  assign w_dup_sum  = {1'b0, r_dup} + 17'(|w_dup);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_dst   <= '0;
      r_out_pid   <= '0;
      r_drop      <= '0;
      r_dup       <= '0;
    end else if (ce) begin
      if (w_load) begin
        r_out_valid <= |w_cmpl;
        if (|w_cmpl) begin
          r_out_data <= w_pkt;
          r_out_src  <= w_src[w_cmpl_idx];
          r_out_dst  <= w_dst[w_cmpl_idx];
          r_out_pid  <= w_pid[w_cmpl_idx];
        end
      end
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_dup  <= w_dup_sum[16]  ? 16'hFFFF : w_dup_sum[15:0];
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_node_start = r_out_src;
  assign out_node_dest  = r_out_dst;
  assign out_packet_id  = r_out_pid;
  assign drop_count     = r_drop;
  assign dup_count      = r_dup;
endmodule

// File: tb/tb_packet_reassembler.sv
// Bench for packet_reassembler: directed scenarios plus randomized traffic
// checked against a per-cycle behavioural model of the reassembly buffer.

module tb_packet_reassembler;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n, ce, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_node_start, in_node_dest, out_node_start, out_node_dest;
  logic [4:0]  in_packet_id, out_packet_id;
  logic [1:0]  in_flit_index;
  logic [16:0] in_data;
  logic [67:0] out_data;
  logic [15:0] drop_count, dup_count;

  int n_chk = 0;
  int n_err = 0;

  packet_reassembler #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_node_start(in_node_start), .in_node_dest(in_node_dest),
    .in_packet_id(in_packet_id), .in_flit_index(in_flit_index), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_node_start(out_node_start), .out_node_dest(out_node_dest),
    .out_packet_id(out_packet_id), .drop_count(drop_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  // Reference model: reassembly slots, output register, counters.
  bit          m_v    [8];
  logic [3:0]  m_mask [8];
  logic [67:0] m_data [8];
  logic [2:0]  m_src  [8];
  logic [2:0]  m_dst  [8];
  logic [4:0]  m_pid  [8];
  int          m_age  [8];
  bit          m_ov;
  logic [67:0] m_od;
  logic [2:0]  m_os, m_odst;
  logic [4:0]  m_opid;
  int          m_drop, m_dup;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 0; m_mask[i] = '0; m_data[i] = '0;
      m_src[i] = '0; m_dst[i] = '0; m_pid[i] = '0; m_age[i] = 0;
    end
    m_ov = 0; m_od = '0; m_os = '0; m_odst = '0; m_opid = '0;
    m_drop = 0; m_dup = 0;
  endtask

  function automatic bit model_ready();
    bit r = 0;
    if (!ce) return 0;
    for (int i = 0; i < 8; i++)
      if (!m_v[i] || (m_src[i] == in_node_start && m_pid[i] == in_packet_id)) r = 1;
    return r;
  endfunction

  task automatic model_step();
    int hit = -1, fr = -1, cm = -1;
    bit acc;
    bit [7:0] tmo;
    if (!ce) return;
    for (int i = 7; i >= 0; i--) begin
      if (m_v[i] && m_src[i] == in_node_start && m_pid[i] == in_packet_id) hit = i;
      if (!m_v[i]) fr = i;
      if (m_v[i] && m_mask[i] == 4'hF) cm = i;
    end
    acc = in_valid && (hit >= 0 || fr >= 0);
    for (int i = 0; i < 8; i++)
      tmo[i] = m_v[i] && m_mask[i] != 4'hF && m_age[i] == TMO-1 && !(acc && hit == i);
    if (!m_ov || out_ready) begin
      m_ov = (cm >= 0);
      if (cm >= 0) begin
        m_od = m_data[cm]; m_os = m_src[cm]; m_odst = m_dst[cm]; m_opid = m_pid[cm];
        m_v[cm] = 0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (m_v[i] && m_mask[i] != 4'hF) m_age[i]++;
      if (tmo[i]) begin
        m_v[i] = 0;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (acc) begin
      if (hit >= 0) begin
        if (m_mask[hit][in_flit_index] && m_dup < 65535) m_dup++;
        if (m_mask[hit] != 4'hF) m_data[hit][(3-int'(in_flit_index))*17 +: 17] = in_data;
        m_mask[hit][in_flit_index] = 1'b1;
        m_age[hit] = 0;
      end else begin
        m_v[fr] = 1; m_src[fr] = in_node_start; m_dst[fr] = in_node_dest; m_pid[fr] = in_packet_id;
        m_mask[fr] = 4'b0001 << in_flit_index;
        m_data[fr] = '0;
        m_data[fr][(3-int'(in_flit_index))*17 +: 17] = in_data;
        m_age[fr] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int node, input int id, input int idx, input logic [16:0] d, input int dst);
    in_valid = 1'b1;
    in_node_start = 3'(node); in_packet_id = 5'(id); in_flit_index = 2'(idx);
    in_data = d; in_node_dest = 3'(dst);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; ce = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    in_node_start = '0; in_node_dest = '0; in_packet_id = '0; in_flit_index = '0; in_data = '0;
    model_reset();
    #3;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_node_start !== '0 || out_node_dest !== '0 || out_packet_id !== '0) begin
      n_err++; $display("FAIL reset_out: valid=%b data=%h src=%0d dst=%0d id=%0d want all 0",
                        out_valid, out_data, out_node_start, out_node_dest, out_packet_id);
    end
    n_chk++;
    if (drop_count !== 16'd0 || dup_count !== 16'd0) begin
      n_err++; $display("FAIL reset_counters: drop=%0d dup=%0d want 0 0", drop_count, dup_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_in_order();
    logic [67:0] exp;
    do_reset(); out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin drive(3, 5, j, 17'(j+1), 6); tick(); end
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL in_order_early: out_valid=%b want 0", out_valid); end
    tick();
    exp = {17'd1, 17'd2, 17'd3, 17'd4};
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== exp || out_node_start !== 3'd3 || out_packet_id !== 5'd5 || out_node_dest !== 3'd6) begin
      n_err++; $display("FAIL in_order_pkt: valid=%b data=%h src=%0d id=%0d dst=%0d want 1 %h 3 5 6",
                        out_valid, out_data, out_node_start, out_packet_id, out_node_dest, exp);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL in_order_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_interleave();
    int ord[4] = '{3, 1, 0, 2};
    logic [67:0] exp_a, exp_b;
    do_reset(); out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, ord[k], 17'(32'h100 + ord[k]), 0); tick();
      drive(4, 2, ord[k], 17'(32'h200 + ord[k]), 0); tick();
    end
    in_valid = 1'b0;
    exp_a = {17'h100, 17'h101, 17'h102, 17'h103};
    exp_b = {17'h200, 17'h201, 17'h202, 17'h203};
    n_chk++;
    if (out_valid !== 1'b1 || out_node_start !== 3'd1 || out_data !== exp_a) begin
      n_err++; $display("FAIL interleave_first: valid=%b src=%0d data=%h want 1 1 %h", out_valid, out_node_start, out_data, exp_a);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_node_start !== 3'd4 || out_data !== exp_b) begin
      n_err++; $display("FAIL interleave_second: valid=%b src=%0d data=%h want 1 4 %h", out_valid, out_node_start, out_data, exp_b);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || drop_count !== 16'd0) begin
      n_err++; $display("FAIL interleave_end: valid=%b drop=%0d want 0 0", out_valid, drop_count);
    end
  endtask

  task automatic test_full();
    do_reset(); out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin drive(n, 7, 0, 17'(n), 0); tick(); end
    drive(0, 8, 0, 17'h1ff, 0); #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_stall: in_ready=%b want 0", in_ready); end
    drive(2, 7, 1, 17'h1, 0); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_existing: in_ready=%b want 1", in_ready); end
    tick();
    for (int j = 1; j < 4; j++) begin drive(0, 7, j, 17'(j), 0); tick(); end
    drive(0, 8, 0, 17'h1ff, 0); #1;
    n_chk++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_still_stalled: in_ready=%b want 0", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_node_start !== 3'd0 || out_packet_id !== 5'd7 || out_data !== {17'd0, 17'd1, 17'd2, 17'd3}) begin
      n_err++; $display("FAIL full_out: valid=%b src=%0d id=%0d data=%h want 1 0 7", out_valid, out_node_start, out_packet_id, out_data);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_freed: in_ready=%b want 1", in_ready); end
    tick();
    for (int j = 1; j < 4; j++) begin drive(0, 8, j, 17'(32'h1f0 + j), 0); tick(); end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_packet_id !== 5'd8 || out_data !== {17'h1ff, 17'h1f1, 17'h1f2, 17'h1f3}) begin
      n_err++; $display("FAIL full_ninth: valid=%b id=%0d data=%h want 1 8", out_valid, out_packet_id, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [67:0] p1, p2;
    do_reset(); out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin drive(5, 1, j, 17'(32'h10 + j), 2); tick(); end
    for (int j = 0; j < 4; j++) begin drive(6, 1, j, 17'(32'h20 + j), 3); tick(); end
    p1 = {17'h10, 17'h11, 17'h12, 17'h13};
    p2 = {17'h20, 17'h21, 17'h22, 17'h23};
    for (int s = 0; s < 5; s++) begin
      if (s == 0) drive(6, 1, 0, 17'h1abcd, 3);
      else in_valid = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== p1 || out_node_start !== 3'd5) begin
        n_err++; $display("FAIL bp_hold%0d: valid=%b data=%h src=%0d want 1 %h 5", s, out_valid, out_data, out_node_start, p1);
      end
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (dup_count !== 16'd1) begin n_err++; $display("FAIL bp_dup_complete: dup=%0d want 1", dup_count); end
    out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== p2 || out_node_start !== 3'd6 || out_node_dest !== 3'd3) begin
      n_err++; $display("FAIL bp_second: valid=%b data=%h src=%0d dst=%0d want 1 %h 6 3", out_valid, out_data, out_node_start, out_node_dest, p2);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_timeout();
    do_reset(); out_ready = 1'b1;
    drive(2, 3, 0, 17'h5, 0); tick();
    in_valid = 1'b0;
    repeat (TMO-1) tick();
    n_chk++;
    if (drop_count !== 16'd0) begin n_err++; $display("FAIL tmo_before: drop=%0d want 0", drop_count); end
    tick();
    n_chk++;
    if (drop_count !== 16'd1) begin n_err++; $display("FAIL tmo_evict: drop=%0d want 1", drop_count); end
    drive(2, 4, 0, 17'h6, 0); tick();
    in_valid = 1'b0;
    repeat (TMO-1) tick();
    drive(2, 4, 1, 17'h7, 0); tick();
    in_valid = 1'b0;
    n_chk++;
    if (drop_count !== 16'd1) begin n_err++; $display("FAIL tmo_flit_wins: drop=%0d want 1", drop_count); end
    repeat (TMO-1) tick();
    n_chk++;
    if (drop_count !== 16'd1) begin n_err++; $display("FAIL tmo_rearm_before: drop=%0d want 1", drop_count); end
    tick();
    n_chk++;
    if (drop_count !== 16'd2) begin n_err++; $display("FAIL tmo_rearm_evict: drop=%0d want 2", drop_count); end
  endtask

  task automatic test_dup_reset();
    do_reset(); out_ready = 1'b0;
    drive(1, 1, 2, 17'h0aaaa, 0); tick();
    drive(1, 1, 2, 17'h05555, 0); tick();
    in_valid = 1'b0;
    n_chk++;
    if (dup_count !== 16'd1) begin n_err++; $display("FAIL dup_count: dup=%0d want 1", dup_count); end
    drive(1, 1, 0, 17'h30, 0); tick();
    drive(1, 1, 1, 17'h31, 0); tick();
    drive(1, 1, 3, 17'h33, 0); tick();
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== {17'h30, 17'h31, 17'h05555, 17'h33}) begin
      n_err++; $display("FAIL dup_data: valid=%b data=%h want 1 second write used", out_valid, out_data);
    end
    drive(2, 2, 0, 17'h40, 0); tick();
    drive(2, 2, 1, 17'h41, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== '0 || drop_count !== 16'd0 || dup_count !== 16'd0) begin
      n_err++; $display("FAIL midreset: valid=%b data=%h drop=%0d dup=%0d want 0", out_valid, out_data, drop_count, dup_count);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: in_ready=%b want 1", in_ready); end
    tick();
    drive(2, 2, 2, 17'h42, 0); tick();
    drive(2, 2, 3, 17'h43, 0); tick();
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_cleared: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ce            = ($urandom_range(0, 9) != 0);
      in_valid      = ($urandom_range(0, 9) < 6);
      in_node_start = 3'($urandom_range(0, 7));
      in_packet_id  = 5'($urandom_range(0, 1));
      in_node_dest  = 3'($urandom);
      in_flit_index = 2'($urandom);
      in_data       = 17'($urandom);
      out_ready     = ($urandom_range(0, 9) < 7);
      #1;
      n_chk++;
      if (in_ready !== model_ready()) begin
        n_err++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, in_ready, model_ready());
      end
      n_chk++;
      if (out_valid !== m_ov || (m_ov && {out_data, out_node_start, out_node_dest, out_packet_id} !== {m_od, m_os, m_odst, m_opid})) begin
        n_err++; $display("FAIL rand_out c%0d: valid=%b data=%h src=%0d dst=%0d id=%0d want %b %h %0d %0d %0d",
                          c, out_valid, out_data, out_node_start, out_node_dest, out_packet_id, m_ov, m_od, m_os, m_odst, m_opid);
      end
      n_chk++;
      if (drop_count !== 16'(m_drop) || dup_count !== 16'(m_dup)) begin
        n_err++; $display("FAIL rand_counters c%0d: drop=%0d dup=%0d want %0d %0d", c, drop_count, dup_count, m_drop, m_dup);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_interleave();
    test_full();
    test_backpressure();
    test_timeout();
    test_dup_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
